// File: rtl/t05_htree_pkg.sv
// Shared types and helpers for the Huffman tree-node builder.
// Helpers take widths as arguments so one package serves every parameterisation.
package t05_htree_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_NODE, ST_RD_C1, ST_WR_C1, ST_RD_C2, ST_WR_C2, ST_DONE, ST_ERR
  } htree_state_t;

  localparam logic [8:0] HTREE_NONE_CODE = 9'h180;

  // MSB set marks a sum node, except the reserved "no child" code.
  function automatic logic is_sum_node(input logic [31:0] code, input int unsigned char_w,
                                       input logic [31:0] none_code);
    return (((code >> (char_w - 1)) & 32'd1) != 32'd0) && (code != none_code);
  endfunction

  function automatic logic [127:0] pack_node(input logic [127:0] idx, input logic [127:0] c1,
                                             input logic [127:0] c2, input logic [127:0] sum,
                                             input int unsigned char_w, input int unsigned sum_w);
    return (idx << (2 * char_w + sum_w)) | (c1 << (char_w + sum_w)) | (c2 << sum_w) | sum;
  endfunction

endpackage

// File: rtl/t05_htree_builder.sv
// Tree-node builder: writes each accepted merge as a new node, then read-modify-writes
// any sum-node children to null their sum field.
module t05_htree_builder
  import t05_htree_pkg::*;
#(
  parameter int unsigned CHAR_W    = 9,
  parameter int unsigned IDX_W     = 7,
  parameter int unsigned SUM_W     = 46,
  parameter int unsigned MAX_NODES = 128,
  parameter logic [CHAR_W-1:0] NONE_CODE = HTREE_NONE_CODE,
  localparam int unsigned RD_W   = 2 * CHAR_W + SUM_W,
  localparam int unsigned NODE_W = IDX_W + RD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] least1,
  input  logic [CHAR_W-1:0] least2,
  input  logic [SUM_W-1:0]  sum,
  output logic              mem_req,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [NODE_W-1:0] mem_wdata,
  input  logic [RD_W-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic [IDX_W:0]    node_count,
  output logic              node_done,
  output logic              tree_done,
  output logic              err
);

  htree_state_t      state_q, state_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic [CHAR_W-1:0] c1_q, c1_d, c2_q, c2_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              node_done_q, node_done_d, tree_done_q, tree_done_d, err_q, err_d;

  logic ack, c1_sum, c2_sum;
  logic [127:0] node_full;
  logic unused_hi;

  assign ack    = mem_ack && mem_req;
  assign c1_sum = is_sum_node(32'(c1_q), CHAR_W, 32'(NONE_CODE));
  assign c2_sum = is_sum_node(32'(c2_q), CHAR_W, 32'(NONE_CODE));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    sum_d       = sum_q;
    rd_d        = rd_q;
    node_done_d = 1'b0;
    tree_done_d = tree_done_q;
    err_d       = err_q;
    // Dropping en abandons any outstanding SRAM transaction, even one acked this cycle.
    if (!en) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      tree_done_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          c1_d  = least1;
          c2_d  = least2;
          sum_d = sum;
          if (sum == '0) begin
            state_d     = ST_DONE;
            tree_done_d = 1'b1;
          end else if (cnt_q == (IDX_W+1)'(MAX_NODES)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WR_NODE;
          end
        end
        ST_WR_NODE: if (ack) begin
          cnt_d = cnt_q + (IDX_W+1)'(1);
          if (c1_sum)      state_d = ST_RD_C1;
          else if (c2_sum) state_d = ST_RD_C2;
          else begin
            state_d     = ST_IDLE;
            node_done_d = 1'b1;
          end
        end
        ST_RD_C1: if (ack) begin
          rd_d    = mem_rdata;
          state_d = ST_WR_C1;
        end
        ST_WR_C1: if (ack) begin
          if (c2_sum) state_d = ST_RD_C2;
          else begin
            state_d     = ST_IDLE;
            node_done_d = 1'b1;
          end
        end
        ST_RD_C2: if (ack) begin
          rd_d    = mem_rdata;
          state_d = ST_WR_C2;
        end
        ST_WR_C2: if (ack) begin
          state_d     = ST_IDLE;
          node_done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      sum_q       <= '0;
      rd_q        <= '0;
      node_done_q <= 1'b0;
      tree_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      sum_q       <= sum_d;
      rd_q        <= rd_d;
      node_done_q <= node_done_d;
      tree_done_q <= tree_done_d;
      err_q       <= err_d;
    end
  end

  // Memory port is a pure decode of registered state, so it holds steady through ack stalls.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    node_full = '0;
    case (state_q)
      ST_WR_NODE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt_q[IDX_W-1:0];
        node_full = pack_node(128'(cnt_q[IDX_W-1:0]), 128'(c1_q), 128'(c2_q), 128'(sum_q),
                              CHAR_W, SUM_W);
      end
      ST_RD_C1: begin
        mem_req  = 1'b1;
        mem_addr = c1_q[IDX_W-1:0];
      end
      ST_WR_C1: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = c1_q[IDX_W-1:0];
        node_full = pack_node(128'(c1_q[IDX_W-1:0]), 128'(rd_q[RD_W-1 -: CHAR_W]),
                              128'(rd_q[SUM_W +: CHAR_W]), 128'(0), CHAR_W, SUM_W);
      end
      ST_RD_C2: begin
        mem_req  = 1'b1;
        mem_addr = c2_q[IDX_W-1:0];
      end
      ST_WR_C2: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = c2_q[IDX_W-1:0];
        node_full = pack_node(128'(c2_q[IDX_W-1:0]), 128'(rd_q[RD_W-1 -: CHAR_W]),
                              128'(rd_q[SUM_W +: CHAR_W]), 128'(0), CHAR_W, SUM_W);
      end
      default: ;
    endcase
  end

  assign mem_wdata  = node_full[NODE_W-1:0];
  assign unused_hi  = ^node_full[127:NODE_W];
  assign in_ready   = (state_q == ST_IDLE) && en;
  assign node_count = cnt_q;
  assign node_done  = node_done_q;
  assign tree_done  = tree_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_t05_htree_builder.sv
// Directed bench for t05_htree_builder (MAX_NODES=4) with a behavioural SRAM responder.
module tb_t05_htree_builder;

  localparam int NODE_W = 71;
  localparam int RD_W   = 64;

  logic              clk = 1'b0;
  logic              rst, en, in_valid, in_ready;
  logic [8:0]        least1, least2;
  logic [45:0]       sum;
  logic              mem_req, mem_we, mem_ack, node_done, tree_done, err;
  logic [6:0]        mem_addr;
  logic [NODE_W-1:0] mem_wdata;
  logic [RD_W-1:0]   mem_rdata;
  logic [7:0]        node_count;

  t05_htree_builder #(.MAX_NODES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .least1(least1), .least2(least2), .sum(sum),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .node_count(node_count),
    .node_done(node_done), .tree_done(tree_done), .err(err)
  );

  always #5 clk = ~clk;

  int ncomp = 0, nfail = 0;

  // SRAM model: acks a request after ack_delay waiting cycles unless hold is set.
  logic [NODE_W-1:0] mem [0:127];
  logic              lg_we    [0:63];
  logic [6:0]        lg_addr  [0:63];
  logic [NODE_W-1:0] lg_wd    [0:63];
  int log_n = 0, wcnt = 0, ack_delay = 0;
  logic hold = 1'b0;

  always @(negedge clk) begin
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_req && !hold) begin
      if (wcnt >= ack_delay) begin
        mem_ack = 1'b1;
        wcnt = 0;
        lg_we[log_n] = mem_we; lg_addr[log_n] = mem_addr; lg_wd[log_n] = mem_wdata;
        log_n++;
        mem_rdata = mem[mem_addr][RD_W-1:0];
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else wcnt++;
    end else wcnt = 0;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ncomp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic we, input logic [6:0] addr,
                         input logic [NODE_W-1:0] wd);
    chk({tag, ".we"}, 128'(lg_we[idx]), 128'(we));
    chk({tag, ".addr"}, 128'(lg_addr[idx]), 128'(addr));
    if (we) chk({tag, ".wdata"}, 128'(lg_wd[idx]), 128'(wd));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [8:0] l1, input logic [8:0] l2, input logic [45:0] s);
    logic acc;
    acc = 1'b0;
    least1 = l1; least2 = l2; sum = s; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin
        tick();
        acc = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    least1 = 9'h1ff; least2 = 9'h1ff; sum = '1;
    chk("accept", 128'(acc), 128'(1));
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (node_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 128'(seen), 128'(1));
  endtask

  initial begin
    int base;
    logic stable, seen_rd;
    logic [NODE_W-1:0] snap_wd;
    logic [6:0] snap_addr;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    en = 1'b0; in_valid = 1'b0; least1 = '0; least2 = '0; sum = '0;
    rst = 1'b1;
    #1;
    chk("rst.mem_req", 128'(mem_req), 0);
    chk("rst.node_count", 128'(node_count), 0);
    chk("rst.flags", 128'({in_ready, node_done, tree_done, err}), 0);
    #20; rst = 1'b0; en = 1'b1;
    tick();
    chk("idle.in_ready", 128'(in_ready), 128'(1));

    // Leaf merge: one write, node_done one cycle after accept with immediate ack.
    send(9'h041, 9'h042, 46'd5);
    chk("t1.req", 128'({mem_req, mem_we, mem_addr}), 128'({1'b1, 1'b1, 7'd0}));
    tick();
    chk("t1.node_done", 128'(node_done), 128'(1));
    chk("t1.count", 128'(node_count), 128'(1));
    chk("t1.nlog", 128'(log_n), 128'(1));
    chk_log("t1.w", 0, 1'b1, 7'd0, {7'd0, 9'h041, 9'h042, 46'd5});

    // Sum child with a 10-cycle stall on the node write.
    ack_delay = 10;
    send(9'h100, 9'h043, 46'd9);
    snap_addr = mem_addr; snap_wd = mem_wdata; stable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (!mem_req || !mem_we || mem_addr !== snap_addr || mem_wdata !== snap_wd || in_ready)
        stable = 1'b0;
    end
    chk("t2.stall_stable", 128'(stable), 128'(1));
    chk("t2.stall_nlog", 128'(log_n), 128'(1));
    ack_delay = 0;
    wait_done("t2.done");
    chk("t2.nlog", 128'(log_n), 128'(4));
    chk_log("t2.w", 1, 1'b1, 7'd1, {7'd1, 9'h100, 9'h043, 46'd9});
    chk_log("t2.r", 2, 1'b0, 7'd0, '0);
    chk_log("t2.n", 3, 1'b1, 7'd0, {7'd0, 9'h041, 9'h042, 46'd0});
    chk("t2.count", 128'(node_count), 128'(2));

    // Both children sum nodes: W,R,W,R,W.
    tick();
    base = log_n;
    send(9'h100, 9'h101, 46'd20);
    wait_done("t3.done");
    chk("t3.nlog", 128'(log_n - base), 128'(5));
    chk_log("t3.w",  base,     1'b1, 7'd2, {7'd2, 9'h100, 9'h101, 46'd20});
    chk_log("t3.r1", base + 1, 1'b0, 7'd0, '0);
    chk_log("t3.n1", base + 2, 1'b1, 7'd0, {7'd0, 9'h041, 9'h042, 46'd0});
    chk_log("t3.r2", base + 3, 1'b0, 7'd1, '0);
    chk_log("t3.n2", base + 4, 1'b1, 7'd1, {7'd1, 9'h100, 9'h043, 46'd0});

    // NONE_CODE second child: only the first child is nulled.
    tick();
    base = log_n;
    send(9'h102, 9'h180, 46'd7);
    wait_done("t3b.done");
    chk("t3b.nlog", 128'(log_n - base), 128'(3));
    chk_log("t3b.w", base,     1'b1, 7'd3, {7'd3, 9'h102, 9'h180, 46'd7});
    chk_log("t3b.r", base + 1, 1'b0, 7'd2, '0);
    chk_log("t3b.n", base + 2, 1'b1, 7'd2, {7'd2, 9'h100, 9'h101, 46'd0});
    chk("t3b.count", 128'(node_count), 128'(4));

    // Fifth merge overflows a 4-node tree.
    tick();
    base = log_n;
    send(9'h041, 9'h042, 46'd1);
    chk("t5.err", 128'(err), 128'(1));
    chk("t5.in_ready", 128'(in_ready), 128'(0));
    tick(); tick();
    chk("t5.nowrite", 128'({mem_req, 7'(log_n - base)}), 128'(0));
    en = 1'b0;
    tick();
    chk("t5.clear", 128'({err, node_count}), 128'(0));
    en = 1'b1;
    tick();

    // Abort in RD_C1 via en.
    send(9'h041, 9'h042, 46'd3);
    wait_done("t6.leaf");
    tick();
    base = log_n;
    send(9'h100, 9'h043, 46'd4);
    seen_rd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req && !mem_we) begin
        hold = 1'b1;
        seen_rd = 1'b1;
        break;
      end
      tick();
    end
    chk("t6.reached_rd", 128'({seen_rd, mem_addr}), 128'({1'b1, 7'd0}));
    en = 1'b0;
    tick();
    chk("t6.abort", 128'({mem_req, node_count}), 128'(0));
    chk("t6.nlog", 128'(log_n - base), 128'(1));
    hold = 1'b0; en = 1'b1;
    tick();

    // Async reset during WR_NODE drops mem_req immediately.
    ack_delay = 5;
    send(9'h041, 9'h042, 46'd6);
    chk("t6.wr_pending", 128'({mem_req, mem_we}), 128'({1'b1, 1'b1}));
    rst = 1'b1;
    #1;
    chk("t6.rst_req", 128'(mem_req), 128'(0));
    tick();
    rst = 1'b0;
    ack_delay = 0;
    tick();

    // End-of-tree marker: no SRAM access, tree_done held until en drops.
    base = log_n;
    send(9'h041, 9'h042, 46'd0);
    chk("t7.tree_done", 128'(tree_done), 128'(1));
    tick(); tick();
    chk("t7.hold", 128'({tree_done, in_ready, mem_req}), 128'({1'b1, 1'b0, 1'b0}));
    chk("t7.nlog", 128'(log_n - base), 128'(0));
    en = 1'b0;
    tick();
    chk("t7.clear", 128'(tree_done), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
